dca_write_burst_scheduler: RTL and testbench

DCA_WRITE_BURST_SCHEDULER -- requirements
Module: dca_write_burst_scheduler

---
 rtl/dca_write_burst_scheduler.sv | 195 +++++++++++++++++++
 tb/tb_dca_write_burst_scheduler.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dca_write_burst_scheduler.sv
// dca_write_burst_scheduler
// Splits a write command (start address + beat count) into AXI INCR bursts.
// Each burst is offered on the AW channel and, in parallel, as a descriptor
// to the W-beat datapath. Bursts in flight (awaiting B) are counted and
// capped at MAX_OUTSTANDING. The command completes once every B has returned.
// Optional feature macro: DCA_WSCHED_4KB_SPLIT_EN -- when defined, bursts are
// additionally clipped so that none crosses a 4KB address boundary.
module dca_write_burst_scheduler #(
    parameter int BW_ADDR         = 32,
    parameter int BW_AXI_DATA     = 32,
    parameter int MAX_BURST_LEN   = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic               clk,
    input  logic               rstnn,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [BW_ADDR-1:0] cmd_addr,
    input  logic [15:0]        cmd_num_beats,
    output logic               awvalid,
    input  logic               awready,
    output logic [BW_ADDR-1:0] awaddr,
    output logic [7:0]         awlen,
    output logic [2:0]         awsize,
    output logic [1:0]         awburst,
    output logic               txn_valid,
    input  logic               txn_ready,
    output logic [7:0]         txn_alen,
    output logic               txn_last,
    input  logic               bvalid,
    output logic               bready,
    input  logic [1:0]         bresp,
    output logic               busy,
    output logic               done,
    output logic               error
);

    localparam int BYTES_PER_BEAT = BW_AXI_DATA / 8;
    localparam int SIZE_LOG2      = $clog2(BYTES_PER_BEAT);
    localparam int OUT_W          = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [BW_ADDR-1:0] ADDR_LSB_MASK = BW_ADDR'(BYTES_PER_BEAT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [BW_ADDR-1:0] addr_q, addr_d;
    logic [15:0]        rem_q, rem_d;
    logic [OUT_W-1:0]   outst_q, outst_d;
    logic               aw_done_q, aw_done_d;
    logic               txn_done_q, txn_done_d;
    logic               error_q, error_d;

    logic [16:0]        burst_beats;
    logic               can_start;
    logic               aw_fire;
    logic               txn_fire;
    logic               b_fire;
    logic               issue;
`ifdef DCA_WSCHED_4KB_SPLIT_EN
    logic [16:0]        beats_to_4kb;
`endif

    // Size of the current burst: limited by remaining beats, burst cap and (optionally) the 4KB page
    always_comb begin
        burst_beats = {1'b0, rem_q};
        if (burst_beats > 17'(MAX_BURST_LEN)) begin
            burst_beats = 17'(MAX_BURST_LEN);
        end
`ifdef DCA_WSCHED_4KB_SPLIT_EN
        beats_to_4kb = 17'((13'd4096 - {1'b0, addr_q[11:0]}) >> SIZE_LOG2);
        if (burst_beats > beats_to_4kb) begin
            burst_beats = beats_to_4kb;
        end
`endif
    end

    // Next-state, handshake tracking, outstanding count and output decode
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        outst_d    = outst_q;
        aw_done_d  = aw_done_q;
        txn_done_d = txn_done_q;
        error_d    = error_q;

        cmd_ready = (state_q == IDLE);
        busy      = (state_q != IDLE);
        done      = 1'b0;
        bready    = (outst_q != '0);
        error     = error_q;

        // A new burst may only be started while there is room for another B;
        // once one side has handshaken, the count can only have dropped.
        can_start = (outst_q < OUT_W'(MAX_OUTSTANDING));
        awvalid   = (state_q == ISSUE) && !aw_done_q && can_start;
        txn_valid = (state_q == ISSUE) && !txn_done_q && can_start;

        // Fields derive only from addr_q/rem_q, which move solely on issue,
        // so they stay stable while either valid is pending.
        awaddr   = addr_q;
        awsize   = 3'(SIZE_LOG2);
        awburst  = 2'b01;
        awlen    = 8'd0;
        txn_alen = 8'd0;
        txn_last = 1'b0;
        if (state_q == ISSUE) begin
            awlen    = 8'(burst_beats - 17'd1);
            txn_alen = 8'(burst_beats - 17'd1);
            txn_last = (burst_beats == {1'b0, rem_q});
        end

        aw_fire  = awvalid && awready;
        txn_fire = txn_valid && txn_ready;
        b_fire   = bvalid && bready;
        issue    = (state_q == ISSUE) && (aw_done_q || aw_fire) && (txn_done_q || txn_fire);

        if (issue && !b_fire) begin
            outst_d = outst_q + OUT_W'(1);
        end else if (!issue && b_fire) begin
            outst_d = outst_q - OUT_W'(1);
        end

        // Errors are recorded but never stop the command
        if (b_fire && (bresp != 2'b00)) begin
            error_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d     = cmd_addr & ~ADDR_LSB_MASK;
                    rem_d      = cmd_num_beats;
                    error_d    = 1'b0;
                    aw_done_d  = 1'b0;
                    txn_done_d = 1'b0;
                    state_d    = (cmd_num_beats == 16'd0) ? DRAIN : ISSUE;
                end
            end
            ISSUE: begin
                if (issue) begin
                    aw_done_d  = 1'b0;
                    txn_done_d = 1'b0;
                    addr_d     = addr_q + (BW_ADDR'(burst_beats) << SIZE_LOG2);
                    rem_d      = rem_q - burst_beats[15:0];
                    if (txn_last) begin
                        state_d = DRAIN;
                    end
                end else begin
                    if (aw_fire) begin
                        aw_done_d = 1'b1;
                    end
                    if (txn_fire) begin
                        txn_done_d = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (outst_q == '0) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any command in flight
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            outst_q    <= '0;
            aw_done_q  <= 1'b0;
            txn_done_q <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            outst_q    <= outst_d;
            aw_done_q  <= aw_done_d;
            txn_done_q <= txn_done_d;
            error_q    <= error_d;
        end
    end

endmodule

// File: tb/tb_dca_write_burst_scheduler.sv
// Directed testbench for dca_write_burst_scheduler (default parameters).
// Honors DCA_WSCHED_4KB_SPLIT_EN for the 4KB boundary expectations.
module tb_dca_write_burst_scheduler;

    logic        clk = 1'b0;
    logic        rstnn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic [15:0] cmd_num_beats;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        txn_valid;
    logic        txn_ready;
    logic [7:0]  txn_alen;
    logic        txn_last;
    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    logic        busy;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;

    // responder controls
    logic aw_delay_mode;
    logic b_auto;
    logic b_manual;
    logic err_mode;
    int   err_idx;
    int   b_base;
    int   b_cnt = 0;
    int   aw_wait = 0;

    // transaction logs
    logic [31:0] aw_addr_log [16];
    logic [7:0]  aw_len_log  [16];
    logic [7:0]  txn_len_log [16];
    logic        txn_last_log[16];
    int n_aw, n_txn, n_done, n_stab;

    logic        aw_pend = 1'b0;
    logic        txn_pend = 1'b0;
    logic [31:0] aw_hold_addr;
    logic [7:0]  aw_hold_len;
    logic [7:0]  txn_hold_len;
    logic        txn_hold_last;

    bit   found;
    logic err_at_done;
    int   sum;

    always #5 clk = ~clk;

    dca_write_burst_scheduler dut (
        .clk           (clk),
        .rstnn         (rstnn),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_addr      (cmd_addr),
        .cmd_num_beats (cmd_num_beats),
        .awvalid       (awvalid),
        .awready       (awready),
        .awaddr        (awaddr),
        .awlen         (awlen),
        .awsize        (awsize),
        .awburst       (awburst),
        .txn_valid     (txn_valid),
        .txn_ready     (txn_ready),
        .txn_alen      (txn_alen),
        .txn_last      (txn_last),
        .bvalid        (bvalid),
        .bready        (bready),
        .bresp         (bresp),
        .busy          (busy),
        .done          (done),
        .error         (error)
    );

    assign awready   = aw_delay_mode ? (aw_wait >= 3) : 1'b1;
    assign txn_ready = 1'b1;
    assign bvalid    = b_auto ? bready : b_manual;
    assign bresp     = (err_mode && ((b_cnt - b_base) == err_idx)) ? 2'b10 : 2'b00;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // responder counters advance on the edge where the handshake happens
    always @(posedge clk) begin
        if (bvalid && bready) b_cnt <= b_cnt + 1;
        if (awvalid && !awready) aw_wait <= aw_wait + 1;
        else aw_wait <= 0;
    end

    // log handshakes and check field stability while a valid is pending
    always @(negedge clk) begin
        if (aw_pend && awvalid) begin
            n_stab++;
            check("aw_stable_addr", awaddr, aw_hold_addr);
            check("aw_stable_len", awlen, aw_hold_len);
        end
        if (txn_pend && txn_valid) begin
            n_stab++;
            check("txn_stable_len", txn_alen, txn_hold_len);
            check("txn_stable_last", txn_last, txn_hold_last);
        end
        aw_pend       = awvalid && !awready;
        aw_hold_addr  = awaddr;
        aw_hold_len   = awlen;
        txn_pend      = txn_valid && !txn_ready;
        txn_hold_len  = txn_alen;
        txn_hold_last = txn_last;
        if (awvalid && awready) begin
            if (n_aw < 16) begin
                aw_addr_log[n_aw] = awaddr;
                aw_len_log[n_aw]  = awlen;
            end
            n_aw++;
        end
        if (txn_valid && txn_ready) begin
            if (n_txn < 16) begin
                txn_len_log[n_txn]  = txn_alen;
                txn_last_log[n_txn] = txn_last;
            end
            n_txn++;
        end
        if (done) n_done++;
    end

    task automatic clear_logs();
        n_aw   = 0;
        n_txn  = 0;
        n_done = 0;
        n_stab = 0;
    endtask

    // offer a command for one cycle; returns 1 time unit after the accepting edge
    task automatic send_cmd(input logic [31:0] a, input logic [15:0] n);
        check("cmd_ready_idle", cmd_ready, 1'b1);
        cmd_addr      = a;
        cmd_num_beats = n;
        cmd_valid     = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit f, output logic e);
        f = 1'b0;
        e = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                f = 1'b1;
                e = error;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_basic(input string tag);
        clear_logs();
        send_cmd(32'h1000, 16'd40);
        wait_done(200, found, err_at_done);
        check({tag, "_done_seen"}, found, 1'b1);
        check({tag, "_n_aw"}, n_aw, 3);
        check({tag, "_n_txn"}, n_txn, 3);
        check({tag, "_addr0"}, aw_addr_log[0], 32'h1000);
        check({tag, "_addr1"}, aw_addr_log[1], 32'h1040);
        check({tag, "_addr2"}, aw_addr_log[2], 32'h1080);
        check({tag, "_len0"}, aw_len_log[0], 8'd15);
        check({tag, "_len1"}, aw_len_log[1], 8'd15);
        check({tag, "_len2"}, aw_len_log[2], 8'd7);
        check({tag, "_alen2"}, txn_len_log[2], 8'd7);
        check({tag, "_last0"}, txn_last_log[0], 1'b0);
        check({tag, "_last1"}, txn_last_log[1], 1'b0);
        check({tag, "_last2"}, txn_last_log[2], 1'b1);
        check({tag, "_n_done"}, n_done, 1);
        check({tag, "_busy_after"}, busy, 1'b0);
    endtask

    initial begin
        rstnn         = 1'b0;
        cmd_valid     = 1'b0;
        cmd_addr      = '0;
        cmd_num_beats = '0;
        aw_delay_mode = 1'b0;
        b_auto        = 1'b1;
        b_manual      = 1'b0;
        err_mode      = 1'b0;
        err_idx       = 0;
        b_base        = 0;
        clear_logs();

        // reset state
        #12;
        check("rst_awvalid", awvalid, 1'b0);
        check("rst_txn_valid", txn_valid, 1'b0);
        check("rst_bready", bready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_awaddr", awaddr, 32'h0);
        check("rst_awlen", awlen, 8'h0);
        check("rst_txn_alen", txn_alen, 8'h0);
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_awsize", awsize, 3'd2);
        check("rst_awburst", awburst, 2'b01);
        @(posedge clk);
        #1;
        rstnn = 1'b1;
        @(posedge clk);
        #1;

        // 40 beats at 0x1000, everything ready
        run_basic("t1");

        // burst near a 4KB boundary
        clear_logs();
        send_cmd(32'h1FF8, 16'd10);
        wait_done(200, found, err_at_done);
        check("t2_done_seen", found, 1'b1);
`ifdef DCA_WSCHED_4KB_SPLIT_EN
        check("t2_n_aw", n_aw, 2);
        check("t2_addr0", aw_addr_log[0], 32'h1FF8);
        check("t2_len0", aw_len_log[0], 8'd1);
        check("t2_addr1", aw_addr_log[1], 32'h2000);
        check("t2_len1", aw_len_log[1], 8'd7);
        check("t2_last1", txn_last_log[1], 1'b1);
`else
        check("t2_n_aw", n_aw, 1);
        check("t2_addr0", aw_addr_log[0], 32'h1FF8);
        check("t2_len0", aw_len_log[0], 8'd9);
        check("t2_last0", txn_last_log[0], 1'b1);
`endif

        // outstanding limit with B channel held off
        clear_logs();
        b_auto   = 1'b0;
        b_manual = 1'b0;
        send_cmd(32'h0000_8000, 16'd96);
        repeat (20) @(posedge clk);
        #1;
        check("t3_n_aw_cap", n_aw, 4);
        check("t3_awvalid_low", awvalid, 1'b0);
        check("t3_txn_valid_low", txn_valid, 1'b0);
        check("t3_bready", bready, 1'b1);
        b_manual = 1'b1;
        @(posedge clk);
        #1;
        b_manual = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("t3_n_aw_after_b", n_aw, 5);
        check("t3_awvalid_low2", awvalid, 1'b0);
        check("t3_addr4", aw_addr_log[4], 32'h0000_8100);
        b_auto = 1'b1;
        wait_done(200, found, err_at_done);
        check("t3_done_seen", found, 1'b1);
        check("t3_n_aw_total", n_aw, 6);
        check("t3_n_done", n_done, 1);

        // AW ready lags txn ready by 3 cycles
        clear_logs();
        aw_delay_mode = 1'b1;
        send_cmd(32'h0000_0100, 16'd40);
        @(posedge clk);
        #1;
        check("t4_awvalid_wait", awvalid, 1'b1);
        check("t4_txn_valid_done", txn_valid, 1'b0);
        check("t4_awaddr_wait", awaddr, 32'h0000_0100);
        check("t4_n_aw_none_yet", n_aw, 0);
        wait_done(300, found, err_at_done);
        aw_delay_mode = 1'b0;
        check("t4_done_seen", found, 1'b1);
        check("t4_n_aw", n_aw, 3);
        check("t4_n_txn", n_txn, 3);
        sum = 0;
        for (int i = 0; i < 3; i++) sum += int'(aw_len_log[i]) + 1;
        check("t4_aw_beat_sum", sum, 40);
        sum = 0;
        for (int i = 0; i < 3; i++) sum += int'(txn_len_log[i]) + 1;
        check("t4_txn_beat_sum", sum, 40);
        check("t4_addr2", aw_addr_log[2], 32'h0000_0180);
        check("t4_stab_seen", (n_stab > 0), 1'b1);

        // zero-beat command
        clear_logs();
        send_cmd(32'h0000_0200, 16'd0);
        check("t5_done_pulse", done, 1'b1);
        check("t5_busy", busy, 1'b1);
        check("t5_awvalid", awvalid, 1'b0);
        @(posedge clk);
        #1;
        check("t5_done_drop", done, 1'b0);
        check("t5_busy_drop", busy, 1'b0);
        check("t5_n_aw", n_aw, 0);
        check("t5_n_done", n_done, 1);

        // SLVERR on the second of three B responses
        clear_logs();
        err_mode = 1'b1;
        err_idx  = 1;
        b_base   = b_cnt;
        send_cmd(32'h2000, 16'd40);
        wait_done(200, found, err_at_done);
        check("t6_done_seen", found, 1'b1);
        check("t6_err_at_done", err_at_done, 1'b1);
        check("t6_n_aw", n_aw, 3);
        check("t6_err_idle", error, 1'b1);
        err_mode = 1'b0;
        send_cmd(32'h3000, 16'd0);
        check("t6_err_cleared", error, 1'b0);
        @(posedge clk);
        #1;

        // asynchronous reset in the middle of a command
        clear_logs();
        err_mode = 1'b1;
        err_idx  = 0;
        b_base   = b_cnt;
        send_cmd(32'h4000, 16'd96);
        repeat (6) @(posedge clk);
        #1;
        check("t7_err_before", error, 1'b1);
        check("t7_busy_before", busy, 1'b1);
        #2;
        rstnn = 1'b0;
        #1;
        check("t7_awvalid", awvalid, 1'b0);
        check("t7_txn_valid", txn_valid, 1'b0);
        check("t7_bready", bready, 1'b0);
        check("t7_busy", busy, 1'b0);
        check("t7_done", done, 1'b0);
        check("t7_error", error, 1'b0);
        check("t7_awaddr", awaddr, 32'h0);
        check("t7_awlen", awlen, 8'h0);
        check("t7_txn_alen", txn_alen, 8'h0);
        repeat (3) @(posedge clk);
        #1;
        check("t7_no_done", n_done, 0);
        rstnn    = 1'b1;
        err_mode = 1'b0;
        @(posedge clk);
        #1;
        run_basic("t8");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
